// File: rtl/serial_addsub_digit.sv
// Digit-serial two's-complement adder/subtractor, LSB digit first, one
// registered result digit per valid beat with carry-out, overflow and beat count.
module serial_addsub_digit #(
  parameter int DIGIT_W = 1,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic               sub,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               last,
  output logic               sum_vld,
  output logic [DIGIT_W-1:0] sum,
  output logic               sum_last,
  output logic               carry_out,
  output logic               overflow,
  output logic [CNT_W-1:0]   digit_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic               carry;
  logic               mode;
  logic [CNT_W-1:0]   count;

  logic               eff_sub;
  logic               cin;
  logic [DIGIT_W-1:0] bx;
  logic [DIGIT_W-1:0] s;
  logic               c;
  logic               c_into_msb;
  logic [CNT_W-1:0]   cnt_inc;

  always_comb begin
    eff_sub    = (state == IDLE) ? sub : mode;
    cin        = (state == IDLE) ? sub : carry;
    bx         = b ^ {DIGIT_W{eff_sub}};
    {c, s}     = {1'b0, a} + {1'b0, bx} + {{DIGIT_W{1'b0}}, cin};
    // carry into the top bit is recovered from the top-bit sum: s = a ^ b ^ cin
    c_into_msb = s[DIGIT_W-1] ^ a[DIGIT_W-1] ^ bx[DIGIT_W-1];
    cnt_inc    = (&count) ? count : count + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      carry     <= 1'b0;
      mode      <= 1'b0;
      count     <= '0;
      sum_vld   <= 1'b0;
      sum       <= '0;
      sum_last  <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      digit_cnt <= '0;
    end else begin
      sum_vld  <= vld;
      sum_last <= vld & last;
      if (vld) begin
        sum <= s;
        if (last) begin
          carry_out <= c;
          overflow  <= c ^ c_into_msb;
          digit_cnt <= cnt_inc;
          carry     <= 1'b0;
          count     <= '0;
          state     <= IDLE;
        end else begin
          carry <= c;
          count <= cnt_inc;
          mode  <= eff_sub;
          state <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_digit.sv
// Directed bench for serial_addsub_digit: 1-bit, 4-bit and a narrow-counter instance.
module tb_serial_addsub_digit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  // 1-bit digit instances (second one has a 2-bit counter to reach saturation)
  logic       vld1 = 0, sub1 = 0, a1 = 0, b1 = 0, last1 = 0;
  logic       sv1, s1, sl1, co1, ov1;
  logic [7:0] dc1;
  logic       svs, ss, sls, cos, ovs;
  logic [1:0] dcs;

  logic       vld4 = 0, sub4 = 0, last4 = 0;
  logic [3:0] a4 = 0, b4 = 0;
  logic       sv4, sl4, co4, ov4;
  logic [3:0] s4;
  logic [7:0] dc4;

  serial_addsub_digit #(.DIGIT_W(1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .vld(vld1), .sub(sub1), .a(a1), .b(b1), .last(last1),
    .sum_vld(sv1), .sum(s1), .sum_last(sl1), .carry_out(co1), .overflow(ov1),
    .digit_cnt(dc1));

  serial_addsub_digit #(.DIGIT_W(1), .CNT_W(2)) us (
    .clk(clk), .rst(rst), .vld(vld1), .sub(sub1), .a(a1), .b(b1), .last(last1),
    .sum_vld(svs), .sum(ss), .sum_last(sls), .carry_out(cos), .overflow(ovs),
    .digit_cnt(dcs));

  serial_addsub_digit #(.DIGIT_W(4), .CNT_W(8)) u4 (
    .clk(clk), .rst(rst), .vld(vld4), .sub(sub4), .a(a4), .b(b4), .last(last4),
    .sum_vld(sv4), .sum(s4), .sum_last(sl4), .carry_out(co4), .overflow(ov4),
    .digit_cnt(dc4));

  task automatic drive1(input logic v, input logic sb, input logic aa,
                        input logic bb, input logic l);
    @(negedge clk);
    vld1 = v; sub1 = sb; a1 = aa; b1 = bb; last1 = l;
    vld4 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic v, input logic sb, input logic [3:0] aa,
                        input logic [3:0] bb, input logic l);
    @(negedge clk);
    vld4 = v; sub4 = sb; a4 = aa; b4 = bb; last4 = l;
    vld1 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    vld1 = 1'b0; vld4 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (sv1 !== 1'b0) begin n_fail++; $display("FAIL reset_sum_vld got %b want 0", sv1); end
    n_checks++; if (s4 !== 4'h0) begin n_fail++; $display("FAIL reset_sum got %h want 0", s4); end
    n_checks++; if (sl1 !== 1'b0) begin n_fail++; $display("FAIL reset_sum_last got %b want 0", sl1); end
    n_checks++; if ({co1, ov1} !== 2'b00) begin n_fail++; $display("FAIL reset_co_ov got %b want 00", {co1, ov1}); end
    n_checks++; if (dc1 !== 8'd0) begin n_fail++; $display("FAIL reset_digit_cnt got %0d want 0", dc1); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // 5 + 3 in 4 bits: 0101 + 0011 = 1000, signed overflow
  task automatic test_add();
    logic [3:0] av = 4'b0101, bv = 4'b0011, ev = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      drive1(1'b1, 1'b0, av[i], bv[i], i == 3);
      n_checks++; if (sv1 !== 1'b1 || s1 !== ev[i]) begin n_fail++; $display("FAIL add_digit%0d got vld=%b sum=%b want vld=1 sum=%b", i, sv1, s1, ev[i]); end
      n_checks++; if (sl1 !== (i == 3)) begin n_fail++; $display("FAIL add_last%0d got %b want %b", i, sl1, (i == 3)); end
    end
    n_checks++; if ({co1, ov1} !== 2'b01) begin n_fail++; $display("FAIL add_co_ov got %b want 01", {co1, ov1}); end
    n_checks++; if (dc1 !== 8'd4) begin n_fail++; $display("FAIL add_digit_cnt got %0d want 4", dc1); end
    n_checks++; if (dcs !== 2'd3 || ss !== 1'b1 || ovs !== 1'b1) begin n_fail++; $display("FAIL sat_cnt got cnt=%0d sum=%b ov=%b want cnt=3 sum=1 ov=1", dcs, ss, ovs); end
    idle();
  endtask

  // 3 - 5 = -2 (1110); sub toggles on later beats and must be ignored
  task automatic test_sub();
    logic [3:0] av = 4'b0011, bv = 4'b0101, ev = 4'b1110, sv = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      drive1(1'b1, sv[i], av[i], bv[i], i == 3);
      n_checks++; if (s1 !== ev[i]) begin n_fail++; $display("FAIL sub_digit%0d got %b want %b", i, s1, ev[i]); end
    end
    n_checks++; if ({co1, ov1} !== 2'b00) begin n_fail++; $display("FAIL sub_co_ov got %b want 00", {co1, ov1}); end
    n_checks++; if (dc1 !== 8'd4 || sl1 !== 1'b1) begin n_fail++; $display("FAIL sub_cnt_last got cnt=%0d last=%b want 4 1", dc1, sl1); end
    idle();
  endtask

  // 0xF0 + 0x20 = 0x110 with 4-bit digits
  task automatic test_wide();
    drive4(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    n_checks++; if (sv4 !== 1'b1 || s4 !== 4'h0 || sl4 !== 1'b0) begin n_fail++; $display("FAIL wide_digit0 got vld=%b sum=%h last=%b want 1 0 0", sv4, s4, sl4); end
    drive4(1'b1, 1'b0, 4'hF, 4'h2, 1'b1);
    n_checks++; if (s4 !== 4'h1 || sl4 !== 1'b1) begin n_fail++; $display("FAIL wide_digit1 got sum=%h last=%b want 1 1", s4, sl4); end
    n_checks++; if ({co4, ov4} !== 2'b10) begin n_fail++; $display("FAIL wide_co_ov got %b want 10", {co4, ov4}); end
    n_checks++; if (dc4 !== 8'd2) begin n_fail++; $display("FAIL wide_digit_cnt got %0d want 2", dc4); end
    idle();
  endtask

  task automatic test_bubbles();
    drive1(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++; if (s1 !== 1'b0 || sv1 !== 1'b1) begin n_fail++; $display("FAIL bub_digit0 got %b/%b want 0/1", s1, sv1); end
    drive1(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    n_checks++; if (sv1 !== 1'b0 || sl1 !== 1'b0 || s1 !== 1'b0) begin n_fail++; $display("FAIL bub_gap1 got vld=%b last=%b sum=%b want 0 0 0", sv1, sl1, s1); end
    drive1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (s1 !== 1'b0) begin n_fail++; $display("FAIL bub_digit1 got %b want 0", s1); end
    drive1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (s1 !== 1'b0) begin n_fail++; $display("FAIL bub_digit2 got %b want 0", s1); end
    drive1(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++; if (sv1 !== 1'b0 || sl1 !== 1'b0) begin n_fail++; $display("FAIL bub_gap2 got vld=%b last=%b want 0 0", sv1, sl1); end
    drive1(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (s1 !== 1'b1 || sl1 !== 1'b1) begin n_fail++; $display("FAIL bub_digit3 got sum=%b last=%b want 1 1", s1, sl1); end
    n_checks++; if ({co1, ov1} !== 2'b01 || dc1 !== 8'd4) begin n_fail++; $display("FAIL bub_final got co_ov=%b cnt=%0d want 01 4", {co1, ov1}, dc1); end
    idle();
  endtask

  task automatic test_back_to_back();
    drive1(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    n_checks++; if (s1 !== 1'b0 || sl1 !== 1'b1 || co1 !== 1'b1 || ov1 !== 1'b1) begin n_fail++; $display("FAIL b2b_add got sum=%b last=%b co=%b ov=%b want 0 1 1 1", s1, sl1, co1, ov1); end
    n_checks++; if (dc1 !== 8'd1) begin n_fail++; $display("FAIL b2b_add_cnt got %0d want 1", dc1); end
    drive1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++; if (s1 !== 1'b0 || co1 !== 1'b1 || ov1 !== 1'b0) begin n_fail++; $display("FAIL b2b_sub got sum=%b co=%b ov=%b want 0 1 0", s1, co1, ov1); end
    n_checks++; if (dc1 !== 8'd1 || sv1 !== 1'b1) begin n_fail++; $display("FAIL b2b_sub_cnt got cnt=%0d vld=%b want 1 1", dc1, sv1); end
    idle();
  endtask

  // Abort both narrow and wide operations mid-flight, then rerun cleanly
  task automatic test_mid_reset();
    @(negedge clk);
    vld1 = 1'b1; sub1 = 1'b0; a1 = 1'b1; b1 = 1'b1; last1 = 1'b0;
    vld4 = 1'b1; sub4 = 1'b0; a4 = 4'hF; b4 = 4'h2; last4 = 1'b0;
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1; vld4 = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if ({sv1, s1, sl1, co1, ov1} !== 5'b0) begin n_fail++; $display("FAIL rst_mid_u1 got %b want 00000", {sv1, s1, sl1, co1, ov1}); end
    n_checks++; if (dc1 !== 8'd0 || dc4 !== 8'd0) begin n_fail++; $display("FAIL rst_mid_cnt got %0d/%0d want 0/0", dc1, dc4); end
    n_checks++; if ({sv4, s4, sl4, co4, ov4} !== 8'b0) begin n_fail++; $display("FAIL rst_mid_u4 got %b want 0", {sv4, s4, sl4, co4, ov4}); end
    vld1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    test_wide();
    test_add();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_wide();
    test_bubbles();
    test_back_to_back();
    test_mid_reset();
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
